entropy_decode_ac_level_coefficients: RTL

ENTROPY_DECODE_AC_LEVEL_COEFFICIENTS -- requirements
Module: entropy_decode_ac_level_coefficients

---
 rtl/entropy_decode_ac_level_coefficients_if.sv | 24 ++
 rtl/entropy_decode_ac_level_coefficients.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/entropy_decode_ac_level_coefficients_if.sv
// Bundles the control, bitstream and result signals of the AC level decoder.
// The master modport drives requests and bits; the slave modport is the decoder.
interface entropy_decode_ac_level_coefficients_if;
  logic               slice_start;
  logic               level_req;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic               busy;
  logic               output_valid;
  logic signed [31:0] level;
  logic        [31:0] abs_level_minus_1;
  logic               error;

  modport master (
    output slice_start, level_req, bit_in, bit_valid,
    input  bit_ready, busy, output_valid, level, abs_level_minus_1, error
  );

  modport slave (
    input  slice_start, level_req, bit_in, bit_valid,
    output bit_ready, busy, output_valid, level, abs_level_minus_1, error
  );
endinterface

// File: rtl/entropy_decode_ac_level_coefficients.sv
// Adaptive Rice / Exp-Golomb decoder for AC coefficient levels.
// The codebook (Rice threshold T, Exp-Golomb order k) follows the magnitude of
// the previous level. Define AC_LEVEL_DEC_ERR_EN to abort with an error pulse
// when the zero prefix reaches 17; otherwise the prefix saturates at 31.
module entropy_decode_ac_level_coefficients (
  input logic                                   clk,
  input logic                                   reset_n,
  entropy_decode_ac_level_coefficients_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPrefix = 3'd1;
  localparam logic [2:0] StSuffix = 3'd2;
  localparam logic [2:0] StSign   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic        [2:0]  r_state;
  logic        [31:0] r_prev;
  logic        [4:0]  r_z;
  logic        [1:0]  r_t;
  logic        [1:0]  r_k;
  logic        [4:0]  r_len;
  logic        [4:0]  r_cnt;
  logic        [31:0] r_s;
  logic        [31:0] r_abs;
  logic        [31:0] r_abs_out;
  logic signed [31:0] r_level;
`ifdef AC_LEVEL_DEC_ERR_EN
  logic               r_error;
`endif

  logic        [31:0] w_prev_src;
  logic        [1:0]  w_t;
  logic        [1:0]  w_k;
  logic               w_ready;
  logic               w_fire;
  logic        [5:0]  w_len_raw;
  logic        [4:0]  w_len;
  logic        [31:0] w_s_next;
  logic        [31:0] w_mag;

  // Magnitude minus one from the Exp-Golomb part: ((1<<len)|s) - (1<<k) + T.
  function automatic logic [31:0] calc_abs(input logic [4:0] len, input logic [31:0] s,
                                           input logic [1:0] k, input logic [1:0] t);
    return ((32'd1 << len) | s) - (32'd1 << k) + {30'd0, t};
  endfunction

  // Codebook selection; a coincident slice_start means the history is already reset.
  always_comb begin
    w_prev_src = bus.slice_start ? 32'd1 : r_prev;
    w_t        = 2'd0;
    w_k        = 2'd2;
    if (w_prev_src == 32'd0) begin
      w_t = 2'd3;
      w_k = 2'd2;
    end else if (w_prev_src == 32'd1) begin
      w_t = 2'd2;
      w_k = 2'd1;
    end else if (w_prev_src == 32'd2) begin
      w_t = 2'd3;
      w_k = 2'd1;
    end else if (w_prev_src == 32'd3) begin
      w_t = 2'd0;
      w_k = 2'd0;
    end else if (w_prev_src < 32'd8) begin
      w_t = 2'd0;
      w_k = 2'd1;
    end
  end

  // Handshake, suffix length (z - T + k, clamped to 31) and the signed output level.
  always_comb begin
    w_ready   = (r_state == StPrefix) || (r_state == StSuffix) || (r_state == StSign);
    w_fire    = w_ready & bus.bit_valid;
    w_len_raw = {1'b0, r_z} - {4'd0, r_t} + {4'd0, r_k};
    w_len     = (w_len_raw > 6'd31) ? 5'd31 : w_len_raw[4:0];
    w_s_next  = {r_s[30:0], bus.bit_in};
    w_mag     = r_abs + 32'd1;
  end

  assign bus.bit_ready         = w_ready;
  assign bus.busy              = (r_state != StIdle);
  assign bus.output_valid      = (r_state == StDone);
  assign bus.level             = r_level;
  assign bus.abs_level_minus_1 = r_abs_out;
`ifdef AC_LEVEL_DEC_ERR_EN
  assign bus.error             = r_error;
`else
  assign bus.error             = 1'b0;
`endif

  // Decoder FSM, codebook history and registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_prev    <= 32'd1;
      r_z       <= 5'd0;
      r_t       <= 2'd0;
      r_k       <= 2'd0;
      r_len     <= 5'd0;
      r_cnt     <= 5'd0;
      r_s       <= 32'd0;
      r_abs     <= 32'd0;
      r_abs_out <= 32'd0;
      r_level   <= 32'sd0;
`ifdef AC_LEVEL_DEC_ERR_EN
      r_error   <= 1'b0;
`endif
    end else begin
`ifdef AC_LEVEL_DEC_ERR_EN
      r_error <= 1'b0;
`endif
      if (bus.slice_start && (r_state != StIdle)) begin
        r_prev  <= 32'd1;
        r_state <= StIdle;
        if (bus.level_req) begin
          r_t     <= w_t;
          r_k     <= w_k;
          r_z     <= 5'd0;
          r_s     <= 32'd0;
          r_state <= StPrefix;
        end
      end else begin
        if (bus.slice_start) r_prev <= 32'd1;
        case (r_state)
          StIdle: begin
            if (bus.level_req) begin
              r_t     <= w_t;
              r_k     <= w_k;
              r_z     <= 5'd0;
              r_s     <= 32'd0;
              r_state <= StPrefix;
            end
          end
          StPrefix: begin
            if (w_fire) begin
              if (!bus.bit_in) begin
`ifdef AC_LEVEL_DEC_ERR_EN
                if (r_z == 5'd16) begin
                  r_error <= 1'b1;
                  r_state <= StIdle;
                end else begin
                  r_z <= r_z + 5'd1;
                end
`else
                if (r_z != 5'd31) r_z <= r_z + 5'd1;
`endif
              end else if (r_z < {3'd0, r_t}) begin
                r_abs   <= {27'd0, r_z};
                r_state <= StSign;
              end else if (w_len == 5'd0) begin
                r_abs   <= calc_abs(5'd0, 32'd0, r_k, r_t);
                r_state <= StSign;
              end else begin
                r_len   <= w_len;
                r_cnt   <= w_len;
                r_state <= StSuffix;
              end
            end
          end
          StSuffix: begin
            if (w_fire) begin
              r_s   <= w_s_next;
              r_cnt <= r_cnt - 5'd1;
              if (r_cnt == 5'd1) begin
                r_abs   <= calc_abs(r_len, w_s_next, r_k, r_t);
                r_state <= StSign;
              end
            end
          end
          StSign: begin
            if (w_fire) begin
              r_abs_out <= r_abs;
              r_level   <= bus.bit_in ? -$signed(w_mag) : $signed(w_mag);
              r_prev    <= r_abs;
              r_state   <= StDone;
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule
